// File: rtl/aud_dma_pkg.sv
// Shared definitions for the audio read DMA: controller state encoding,
// fixed AXI attribute encodings and the beat-to-byte helper.
package aud_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } dma_state_t;

    localparam logic [2:0]  AXI_SIZE_64    = 3'd3;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned BYTES_PER_BEAT = 8;

    // Byte span covered by a burst of 'beats' 64-bit beats.
    function automatic logic [31:0] burst_bytes(input logic [4:0] beats);
        return 32'(beats) * 32'(BYTES_PER_BEAT);
    endfunction

endpackage

// File: rtl/aud_rd_fifo.sv
// Synchronous first-word-fall-through FIFO for fetched sample words.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, push_data    write side (a push into a full FIFO is dropped
//                      unless a pop happens in the same cycle)
//   pop                read side; ignored while empty
//   pop_data           head entry, valid whenever not_empty is high
//   not_empty          registered "data available" flag
//   free               number of unused entries
module aud_rd_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          not_empty_r;
    logic [AW:0]   count_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify push/pop and compute the next fill level.
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        push_ok_s = push && ((count_r != DEPTH_C) || pop_ok_s);
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Sample storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, fill level and the registered non-empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            not_empty_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_s;
            not_empty_r <= (count_s != '0);
        end
    end

    assign pop_data  = mem_r[rd_ptr_r];
    assign not_empty = not_empty_r;
    assign free      = DEPTH_C - count_r;

endmodule

// File: rtl/audio_rd_dma.sv
// AXI read-only DMA master feeding the audio output engine.
// Fetches a contiguous buffer of 64-bit words in INCR bursts (one burst
// outstanding), buffers them in a FWFT FIFO and streams them out on a
// valid/ready sample interface. Supports single-shot and ring playback.
// Ports:
//   gclk, gresetn                    clock, async active-low reset
//   cfg_start/stop/base/words/loop   transfer control
//   busy, done, err                  status (err is sticky until cfg_start)
//   aid..aburst, aready              AXI read address channel
//   rid, rdata, rlast, rvalid, rready AXI read data channel
//   smp_data, smp_valid, smp_ready   sample stream to the audio engine
module audio_rd_dma
    import aud_dma_pkg::*;
#(
    parameter int              ID_W        = 4,
    parameter logic [ID_W-1:0] AXI_ID      = ID_W'(4'h1),
    parameter int              BURST_BEATS = 8,
    parameter int              FIFO_DEPTH  = 32
) (
    input  logic            gclk,
    input  logic            gresetn,
    input  logic            cfg_start,
    input  logic            cfg_stop,
    input  logic [31:0]     cfg_base,
    input  logic [15:0]     cfg_words,
    input  logic            cfg_loop,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [ID_W-1:0] aid,
    output logic [31:0]     aaddr,
    output logic            avalid,
    output logic            awrite,
    output logic [3:0]      alen,
    output logic [2:0]      asize,
    output logic [1:0]      aburst,
    input  logic            aready,
    input  logic [ID_W-1:0] rid,
    input  logic [63:0]     rdata,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [63:0]     smp_data,
    output logic            smp_valid,
    input  logic            smp_ready
);

    localparam int          FW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0]  BB_LEN     = 5'(BURST_BEATS);
    localparam logic [15:0] BB_WORDS   = 16'(BURST_BEATS);
    localparam logic [FW-1:0] BB_FREE  = FW'(BURST_BEATS);
    // 16-beat bursts span 128 bytes, so the base needs 128-byte alignment
    // to keep every burst inside one 4 KB page.
    localparam logic [31:0] ALIGN_MASK = (BURST_BEATS == 16) ? 32'hFFFF_FF80
                                                             : 32'hFFFF_FFC0;

    // Beats in the next burst given the words still to fetch.
    function automatic logic [4:0] burst_len(input logic [15:0] rem);
        if (rem >= BB_WORDS) begin
            return BB_LEN;
        end else begin
            return rem[4:0];
        end
    endfunction

    // AXI length encoding (beats - 1).
    function automatic logic [3:0] to_alen(input logic [4:0] beats);
        logic [4:0] tmp;
        tmp = beats - 5'd1;
        return tmp[3:0];
    endfunction

    dma_state_t    state_r, nxt_state_s;
    logic [31:0]   base_r, nxt_base_s;
    logic [15:0]   words_r, nxt_words_s;
    logic          loop_r, nxt_loop_s;
    logic [15:0]   remaining_r, nxt_remaining_s;
    logic [4:0]    beats_left_r, nxt_beats_left_s;
    logic          stop_pend_r, nxt_stop_s;
    logic          err_r, nxt_err_s;
    logic          busy_r, nxt_busy_s;
    logic          done_r, nxt_done_s;
    logic          avalid_r, nxt_avalid_s;
    logic [31:0]   aaddr_r, nxt_aaddr_s;
    logic [3:0]    alen_r, nxt_alen_s;
    logic          rready_r, nxt_rready_s;

    logic          stop_now_s;
    logic          beat_s;
    logic          last_exp_s;
    logic [4:0]    cur_len_s;
    logic          fifo_push_s;
    logic [FW-1:0] fifo_free_s;
    logic          fifo_not_empty_s;
    logic [63:0]   fifo_data_s;

    // Controller state register.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Next-state, address generation, beat accounting and status updates.
    always_comb begin
        nxt_state_s      = state_r;
        nxt_base_s       = base_r;
        nxt_words_s      = words_r;
        nxt_loop_s       = loop_r;
        nxt_remaining_s  = remaining_r;
        nxt_beats_left_s = beats_left_r;
        nxt_stop_s       = stop_pend_r | cfg_stop;
        nxt_err_s        = err_r;
        nxt_busy_s       = busy_r;
        nxt_done_s       = 1'b0;
        nxt_avalid_s     = avalid_r;
        nxt_aaddr_s      = aaddr_r;
        nxt_alen_s       = alen_r;
        nxt_rready_s     = rready_r;
        fifo_push_s      = 1'b0;
        stop_now_s       = stop_pend_r | cfg_stop;
        beat_s           = rvalid & rready_r;
        last_exp_s       = (beats_left_r == 5'd1);
        cur_len_s        = {1'b0, alen_r} + 5'd1;

        case (state_r)
            ST_IDLE: begin
                nxt_stop_s = 1'b0;
                if (cfg_start) begin
                    nxt_err_s = 1'b0;
                    if (cfg_words != 16'd0) begin
                        nxt_state_s     = ST_REQ;
                        nxt_busy_s      = 1'b1;
                        nxt_base_s      = cfg_base & ALIGN_MASK;
                        nxt_words_s     = cfg_words;
                        nxt_loop_s      = cfg_loop;
                        nxt_remaining_s = cfg_words;
                        nxt_aaddr_s     = cfg_base & ALIGN_MASK;
                        nxt_alen_s      = to_alen(burst_len(cfg_words));
                    end else begin
                        // Empty buffer: nothing to fetch, just acknowledge.
                        nxt_done_s = 1'b1;
                    end
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (avalid_r) begin
                    if (aready) begin
                        nxt_avalid_s     = 1'b0;
                        nxt_rready_s     = 1'b1;
                        nxt_state_s      = ST_DATA;
                        nxt_beats_left_s = cur_len_s;
                        nxt_remaining_s  = remaining_r - 16'(cur_len_s);
                    end else begin
                        nxt_avalid_s = 1'b1;
                    end
                end else if (stop_now_s) begin
                    // No request issued yet, so a stop can take effect now.
                    nxt_state_s = ST_IDLE;
                    nxt_busy_s  = 1'b0;
                    nxt_stop_s  = 1'b0;
                end else if (fifo_free_s >= BB_FREE) begin
                    // Credit check: the whole burst is guaranteed to fit.
                    nxt_avalid_s = 1'b1;
                end else begin
                    nxt_avalid_s = 1'b0;
                end
            end

            ST_DATA: begin
                if (beat_s) begin
                    if (rid == AXI_ID) begin
                        fifo_push_s = 1'b1;
                    end else begin
                        nxt_err_s = 1'b1;
                    end
                    if (rlast != last_exp_s) begin
                        nxt_err_s = 1'b1;
                    end else begin
                        nxt_err_s = nxt_err_s;
                    end
                    nxt_beats_left_s = beats_left_r - 5'd1;
                    // The burst ends on beat count alone; rlast only flags errors.
                    if (last_exp_s) begin
                        nxt_rready_s = 1'b0;
                        if ((remaining_r != 16'd0) && !stop_now_s) begin
                            nxt_state_s = ST_REQ;
                            nxt_aaddr_s = aaddr_r + burst_bytes(cur_len_s);
                            nxt_alen_s  = to_alen(burst_len(remaining_r));
                        end else if ((remaining_r == 16'd0) && loop_r && !stop_now_s) begin
                            nxt_state_s     = ST_REQ;
                            nxt_aaddr_s     = base_r;
                            nxt_remaining_s = words_r;
                            nxt_alen_s      = to_alen(burst_len(words_r));
                        end else begin
                            nxt_state_s = ST_IDLE;
                            nxt_busy_s  = 1'b0;
                            nxt_stop_s  = 1'b0;
                            nxt_done_s  = !stop_now_s;
                        end
                    end else begin
                        nxt_rready_s = 1'b1;
                    end
                end else begin
                    nxt_state_s = ST_DATA;
                end
            end

            default: begin
                nxt_state_s  = ST_IDLE;
                nxt_busy_s   = 1'b0;
                nxt_avalid_s = 1'b0;
                nxt_rready_s = 1'b0;
                nxt_stop_s   = 1'b0;
            end
        endcase
    end

    // Transfer context and registered outputs.
    always_ff @(posedge gclk or negedge gresetn) begin
        if (!gresetn) begin
            base_r       <= 32'd0;
            words_r      <= 16'd0;
            loop_r       <= 1'b0;
            remaining_r  <= 16'd0;
            beats_left_r <= 5'd0;
            stop_pend_r  <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            avalid_r     <= 1'b0;
            aaddr_r      <= 32'd0;
            alen_r       <= 4'd0;
            rready_r     <= 1'b0;
        end else begin
            base_r       <= nxt_base_s;
            words_r      <= nxt_words_s;
            loop_r       <= nxt_loop_s;
            remaining_r  <= nxt_remaining_s;
            beats_left_r <= nxt_beats_left_s;
            stop_pend_r  <= nxt_stop_s;
            err_r        <= nxt_err_s;
            busy_r       <= nxt_busy_s;
            done_r       <= nxt_done_s;
            avalid_r     <= nxt_avalid_s;
            aaddr_r      <= nxt_aaddr_s;
            alen_r       <= nxt_alen_s;
            rready_r     <= nxt_rready_s;
        end
    end

    aud_rd_fifo #(
        .DW    (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (gclk),
        .rst_n     (gresetn),
        .push      (fifo_push_s),
        .push_data (rdata),
        .pop       (smp_ready),
        .pop_data  (fifo_data_s),
        .not_empty (fifo_not_empty_s),
        .free      (fifo_free_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign aid       = AXI_ID;
    assign aaddr     = aaddr_r;
    assign avalid    = avalid_r;
    assign awrite    = 1'b0;
    assign alen      = alen_r;
    assign asize     = AXI_SIZE_64;
    assign aburst    = AXI_BURST_INCR;
    assign rready    = rready_r;
    assign smp_data  = fifo_data_s;
    assign smp_valid = fifo_not_empty_s;

endmodule

// File: tb/tb_audio_rd_dma.sv
// Scoreboard bench for audio_rd_dma: directed transfers with expected
// bursts and sample words queued up front; monitors pop and compare on
// every address handshake and every accepted sample.
module tb_audio_rd_dma;

    logic        gclk = 1'b0;
    logic        gresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [31:0] cfg_base = 32'd0;
    logic [15:0] cfg_words = 16'd0;
    logic        cfg_loop = 1'b0;
    logic        busy, done, err;
    logic [3:0]  aid;
    logic [31:0] aaddr;
    logic        avalid, awrite;
    logic [3:0]  alen;
    logic [2:0]  asize;
    logic [1:0]  aburst;
    logic        aready = 1'b0;
    logic [3:0]  rid = 4'h1;
    logic [63:0] rdata = 64'd0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [63:0] smp_data;
    logic        smp_valid;
    logic        smp_ready = 1'b0;

    always #5 gclk = ~gclk;

    audio_rd_dma #(
        .ID_W(4), .AXI_ID(4'h1), .BURST_BEATS(8), .FIFO_DEPTH(32)
    ) dut (
        .gclk(gclk), .gresetn(gresetn),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_base(cfg_base),
        .cfg_words(cfg_words), .cfg_loop(cfg_loop),
        .busy(busy), .done(done), .err(err),
        .aid(aid), .aaddr(aaddr), .avalid(avalid), .awrite(awrite),
        .alen(alen), .asize(asize), .aburst(aburst), .aready(aready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_smp[$];
    logic [35:0] exp_burst[$];

    int aready_dly   = 0;
    int bad_rid_beat = -1;
    int rlast_at     = -1;

    int a_total  = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic push_words(input logic [31:0] b, input int n, input int skip);
        for (int i = 0; i < n; i++) begin
            if (i != skip) exp_smp.push_back(word_at(b + 32'(8 * i)));
        end
    endtask

    task automatic push_burst(input logic [31:0] a, input logic [3:0] l);
        exp_burst.push_back({a, l});
    endtask

    task automatic start(input logic [31:0] b, input logic [15:0] w, input logic lp);
        cfg_base  = b;
        cfg_words = w;
        cfg_loop  = lp;
        cfg_start = 1'b1;
        @(negedge gclk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((busy || exp_smp.size() != 0) && t < 3000) begin
            @(negedge gclk);
            t++;
        end
        repeat (3) @(negedge gclk);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_drained"}, 64'(exp_smp.size()), 64'd0);
        check({name, "_bursts"}, 64'(exp_burst.size()), 64'd0);
    endtask

    // AXI read slave: optional address-ready delay with hold checks, then one burst of data.
    initial begin : axi_slave
        logic [31:0] a;
        logic [3:0]  l;
        int          to;
        forever begin
            @(negedge gclk);
            if (gresetn && avalid) begin
                a = aaddr;
                l = alen;
                for (int d = 0; d < aready_dly; d++) begin
                    @(negedge gclk);
                    check("ar_hold_valid", 64'(avalid), 64'd1);
                    check("ar_hold_addr", 64'(aaddr), 64'(a));
                    check("ar_hold_len", 64'(alen), 64'(l));
                end
                aready = 1'b1;
                @(negedge gclk);
                aready = 1'b0;
                for (int i = 0; i <= int'(l); i++) begin
                    rvalid = 1'b1;
                    rdata  = word_at(a + 32'(8 * i));
                    rid    = (i == bad_rid_beat) ? 4'h2 : 4'h1;
                    rlast  = (rlast_at >= 0) ? (i == rlast_at) : (i == int'(l));
                    to = 0;
                    while (!rready && gresetn && to < 100) begin
                        @(negedge gclk);
                        to++;
                    end
                    if (!gresetn) break;
                    if (to >= 100) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rready_timeout: got rready=0 expected 1 within 100 cycles");
                        break;
                    end
                    @(negedge gclk);
                    if (!gresetn) break;
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
    end

    logic        smp_hs = 1'b0, a_hs = 1'b0, done_q = 1'b0;
    logic [63:0] smp_cap;
    logic [31:0] a_cap;
    logic [3:0]  l_cap;

    // Capture handshakes exactly as the DUT sees them at the clock edge.
    always @(posedge gclk) begin
        smp_hs  <= gresetn && smp_valid && smp_ready;
        smp_cap <= smp_data;
        a_hs    <= gresetn && avalid && aready;
        a_cap   <= aaddr;
        l_cap   <= alen;
        done_q  <= gresetn && done;
    end

    // Scoreboard monitor: pop expected values and compare.
    always @(negedge gclk) begin
        logic [35:0] e;
        if (smp_hs) begin
            if (exp_smp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL smp_extra: got %h expected no sample", smp_cap);
            end else begin
                check("smp_data", smp_cap, exp_smp.pop_front());
            end
        end
        if (a_hs) begin
            a_total++;
            if (exp_burst.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ar_extra: got addr %h len %0d expected no burst", a_cap, l_cap);
            end else begin
                e = exp_burst.pop_front();
                check("ar_addr", 64'(a_cap), 64'(e[35:4]));
                check("ar_len", 64'(l_cap), 64'(e[3:0]));
            end
        end
        if (done_q) done_cnt++;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        int d0, a0, t;
        repeat (3) @(negedge gclk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_avalid", 64'(avalid), 64'd0);
        check("rst_aaddr", 64'(aaddr), 64'd0);
        check("rst_alen", 64'(alen), 64'd0);
        check("rst_aid", 64'(aid), 64'h1);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_smp_valid", 64'(smp_valid), 64'd0);
        check("tie_awrite", 64'(awrite), 64'd0);
        check("tie_asize", 64'(asize), 64'd3);
        check("tie_aburst", 64'(aburst), 64'd1);
        gresetn = 1'b1;
        @(negedge gclk);
        smp_ready = 1'b1;

        // Zero-length buffer: done next cycle, never busy.
        d0 = done_cnt;
        start(32'h0000_1000, 16'd0, 1'b0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge gclk);
        check("zero_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Single shot, 20 words, unaligned base bits dropped.
        push_burst(32'h1000, 4'd7);
        push_burst(32'h1040, 4'd7);
        push_burst(32'h1080, 4'd3);
        push_words(32'h1000, 20, -1);
        d0 = done_cnt;
        start(32'h0000_1013, 16'd20, 1'b0);
        wait_idle("t1");
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t1_err", 64'(err), 64'd0);

        // Back-pressure: credit stops requests after the FIFO is committed.
        smp_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_burst(32'h1000 + 32'(64 * i), 4'd7);
        push_words(32'h1000, 64, -1);
        a0 = a_total;
        d0 = done_cnt;
        start(32'h0000_1000, 16'd64, 1'b0);
        repeat (100) @(negedge gclk);
        check("credit_bursts", 64'(a_total - a0), 64'd4);
        check("credit_avalid", 64'(avalid), 64'd0);
        check("credit_smp_valid", 64'(smp_valid), 64'd1);
        smp_ready = 1'b1;
        wait_idle("t2");
        check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Ring playback, stopped during the third burst.
        push_burst(32'h1000, 4'd7);
        push_burst(32'h1040, 4'd1);
        push_burst(32'h1000, 4'd7);
        push_words(32'h1000, 10, -1);
        push_words(32'h1000, 8, -1);
        a0 = a_total;
        d0 = done_cnt;
        start(32'h0000_1000, 16'd10, 1'b1);
        t = 0;
        while ((a_total - a0) < 3 && t < 500) begin
            @(negedge gclk);
            t++;
        end
        repeat (2) @(negedge gclk);
        cfg_stop = 1'b1;
        @(negedge gclk);
        cfg_stop = 1'b0;
        wait_idle("t3");
        repeat (20) @(negedge gclk);
        check("t3_bursts", 64'(a_total - a0), 64'd3);
        check("t3_no_done", 64'(done_cnt - d0), 64'd0);

        // Wrong ID on beat 3: dropped, err sticky.
        bad_rid_beat = 2;
        push_burst(32'h2000, 4'd7);
        push_words(32'h2000, 8, 2);
        d0 = done_cnt;
        start(32'h0000_2000, 16'd8, 1'b0);
        wait_idle("t4");
        bad_rid_beat = -1;
        check("t4_err", 64'(err), 64'd1);
        repeat (5) @(negedge gclk);
        check("t4_err_sticky", 64'(err), 64'd1);
        check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Early rlast on beat 5: err, but all 8 beats consumed.
        rlast_at = 4;
        push_burst(32'h3000, 4'd7);
        push_words(32'h3000, 8, -1);
        d0 = done_cnt;
        start(32'h0000_3000, 16'd8, 1'b0);
        check("t5_err_cleared", 64'(err), 64'd0);
        wait_idle("t5");
        rlast_at = -1;
        check("t5_err", 64'(err), 64'd1);
        check("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Slow aready: address channel held stable.
        aready_dly = 5;
        push_burst(32'h4000, 4'd7);
        push_burst(32'h4040, 4'd7);
        push_words(32'h4000, 16, -1);
        d0 = done_cnt;
        start(32'h0000_4000, 16'd16, 1'b0);
        wait_idle("t6");
        aready_dly = 0;
        check("t6_err", 64'(err), 64'd0);
        check("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Async reset in the middle of a data phase.
        push_burst(32'h5000, 4'd7);
        push_words(32'h5000, 16, -1);
        start(32'h0000_5000, 16'd16, 1'b0);
        t = 0;
        while (!rready && t < 100) begin
            @(negedge gclk);
            t++;
        end
        check("t7_in_data", 64'(rready), 64'd1);
        repeat (2) @(negedge gclk);
        #2;
        gresetn = 1'b0;
        #1;
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_done", 64'(done), 64'd0);
        check("t7_err", 64'(err), 64'd0);
        check("t7_avalid", 64'(avalid), 64'd0);
        check("t7_aaddr", 64'(aaddr), 64'd0);
        check("t7_alen", 64'(alen), 64'd0);
        check("t7_aid", 64'(aid), 64'h1);
        check("t7_rready", 64'(rready), 64'd0);
        check("t7_smp_valid", 64'(smp_valid), 64'd0);
        exp_smp.delete();
        exp_burst.delete();
        @(negedge gclk);
        gresetn = 1'b1;
        repeat (10) @(negedge gclk);
        check("t7_post_idle", 64'(avalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
